// File: rtl/sketch_hot_filter_if.sv
// Hot-address report stream from sketch_hot_filter to the hot-page reporter.
// Carries out_valid/out_ready plus the reported address and estimate.
interface sketch_hot_filter_if #(
  parameter int ADDR_SIZE = 22,
  parameter int CNT_SIZE  = 32
);
  logic                 out_valid;
  logic                 out_ready;
  logic [ADDR_SIZE-1:0] out_addr;
  logic [CNT_SIZE-1:0]  out_cnt;

  modport master (
    output out_valid,
    output out_addr,
    output out_cnt,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_addr,
    input  out_cnt,
    output out_ready
  );
endinterface

// File: rtl/sketch_hot_filter.sv
// Count-min estimate, hot-threshold compare and report FIFO after the sketch.
// Define HOT_DEDUP_EN for >= compare with a round-robin dedup address table.
module sketch_hot_filter #(
  parameter int NUM_HASH    = 4,
  parameter int ADDR_SIZE   = 22,
  parameter int CNT_SIZE    = 32,
  parameter int SKETCH_LAT  = 3,
  parameter int FIFO_DEPTH  = 16,
  parameter int DEDUP_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               query_rst_n,
  input  logic                               in_valid,
  input  logic [ADDR_SIZE-1:0]               in_addr,
  input  logic [NUM_HASH-1:0][CNT_SIZE-1:0]  sketch_cnt_array,
  input  logic [CNT_SIZE-1:0]                threshold,
  sketch_hot_filter_if.master                rpt,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
  output logic [31:0]                        drop_cnt
);
  localparam int LVLS = $clog2(NUM_HASH);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int LW   = PW + 1;

  if (NUM_HASH < 2 || FIFO_DEPTH < 2 || DEDUP_DEPTH < 1 || SKETCH_LAT < 1)
  begin : g_cfg_err
    $error("sketch_hot_filter: unsupported parameters");
  end

  typedef struct packed {
    logic                 v;
    logic [ADDR_SIZE-1:0] a;
  } tag_t;

  typedef struct packed {
    logic [ADDR_SIZE-1:0] a;
    logic [CNT_SIZE-1:0]  c;
  } rpt_t;

  logic clr;
  assign clr = rst || !query_rst_n;

  // tag delay line, matched to sketch latency
  tag_t dl [SKETCH_LAT];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < SKETCH_LAT; i++)
        dl[i] <= '0;
    end else begin
      dl[0] <= '{v: in_valid, a: in_addr};
      for (int i = 1; i < SKETCH_LAT; i++)
        dl[i] <= dl[i-1];
    end
  end

  // min tree: lv[k] holds NUM_HASH>>(k+1) live minima
  logic [NUM_HASH-1:0][CNT_SIZE-1:0] lv  [LVLS];
  tag_t                              lt  [LVLS];
  logic [NUM_HASH-1:0][CNT_SIZE-1:0] src [LVLS];
  tag_t                              stg [LVLS];

  always_comb begin
    src[0] = sketch_cnt_array;
    stg[0] = dl[SKETCH_LAT-1];
    for (int k = 1; k < LVLS; k++) begin
      src[k] = lv[k-1];
      stg[k] = lt[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < LVLS; k++) begin
        lv[k] <= '0;
        lt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < LVLS; k++) begin
        lt[k] <= stg[k];
        lv[k] <= '0;
        for (int i = 0; i < (NUM_HASH >> (k + 1)); i++)
          lv[k][i] <= (src[k][2*i] < src[k][2*i+1]) ?
                      src[k][2*i] : src[k][2*i+1];
      end
    end
  end

  logic [CNT_SIZE-1:0] est;
  tag_t                et;
  assign est = lv[LVLS-1][0];
  assign et  = lt[LVLS-1];

  logic cand;
  logic hot_q;
  rpt_t hot_d;
  logic full;
  logic pop;
  logic wr;
  logic drop;

`ifdef HOT_DEDUP_EN
  localparam int DW = (DEDUP_DEPTH > 1) ? $clog2(DEDUP_DEPTH) : 1;

  logic [ADDR_SIZE-1:0]   dt [DEDUP_DEPTH];
  logic [DEDUP_DEPTH-1:0] dv;
  logic [DW-1:0]          dp;
  logic                   hit;

  // the address being inserted this cycle already counts as present
  always_comb begin
    hit = wr && (hot_d.a == et.a);
    for (int j = 0; j < DEDUP_DEPTH; j++)
      if (dv[j] && dt[j] == et.a)
        hit = 1'b1;
  end

  assign cand = et.v && (threshold != '0) &&
                (est >= threshold) && !hit;

  always_ff @(posedge clk) begin
    if (clr) begin
      dv <= '0;
      dp <= '0;
    end else if (wr) begin
      dt[dp] <= hot_d.a;
      dv[dp] <= 1'b1;
      dp     <= (dp == DW'(DEDUP_DEPTH - 1)) ? '0 : dp + DW'(1);
    end
  end
`else
  assign cand = et.v && (threshold != '0) && (est == threshold);
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      hot_q <= 1'b0;
      hot_d <= '0;
    end else begin
      hot_q <= cand;
      hot_d <= '{a: et.a, c: est};
    end
  end

  // report FIFO; a same-cycle pop makes room for the push
  rpt_t          mem [FIFO_DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  rpt_t          head;

  assign full = (fifo_level == LW'(FIFO_DEPTH));
  assign pop  = rpt.out_valid && rpt.out_ready;
  assign wr   = hot_q && (!full || pop);
  assign drop = hot_q && full && !pop;

  always_ff @(posedge clk) begin
    if (clr) begin
      wp         <= '0;
      rp         <= '0;
      fifo_level <= '0;
    end else begin
      if (wr)
        wp <= wp + PW'(1);
      if (pop)
        rp <= rp + PW'(1);
      fifo_level <= fifo_level + LW'(wr) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr)
      mem[wp] <= hot_d;
  end

  always_ff @(posedge clk) begin
    if (rst)
      drop_cnt <= '0;
    else if (drop && query_rst_n && drop_cnt != '1)
      drop_cnt <= drop_cnt + 32'd1;
  end

  assign head          = mem[rp];
  assign rpt.out_valid = (fifo_level != '0);
  assign rpt.out_addr  = rpt.out_valid ? head.a : '0;
  assign rpt.out_cnt   = rpt.out_valid ? head.c : '0;

endmodule
